// File: rtl/sra_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sra_arbiter                                                  |
// | Description : Round-robin arbiter sharing one sra slave port among         |
// |               NUM_REQ masters, one outstanding transaction, with timeout.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sra_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_WIDTH       = 8,
    parameter int M_USER_BITS      = 2,
    parameter int S_USER_BITS      = 2,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [NUM_REQ-1:0]                                  req_valid,
    output logic [NUM_REQ-1:0]                                  req_ready,
    input  logic [NUM_REQ*8*DATA_WIDTH_BYTES-1:0]               req_data,
    input  logic [NUM_REQ*(M_USER_BITS+ADDR_WIDTH)-1:0]         req_user,
    output logic [NUM_REQ-1:0]                                  rsp_valid,
    input  logic [NUM_REQ-1:0]                                  rsp_ready,
    output logic [8*DATA_WIDTH_BYTES-1:0]                       rsp_data,
    output logic [S_USER_BITS+ADDR_WIDTH-1:0]                   rsp_user,
    output logic                                                rsp_err,
    output logic                                                m_valid,
    input  logic                                                m_ready,
    output logic [8*DATA_WIDTH_BYTES-1:0]                       m_data,
    output logic [M_USER_BITS+ADDR_WIDTH-1:0]                   m_user,
    input  logic                                                s_valid,
    output logic                                                s_ready,
    input  logic [8*DATA_WIDTH_BYTES-1:0]                       s_data,
    input  logic [S_USER_BITS+ADDR_WIDTH-1:0]                   s_user,
    output logic                                                busy,
    output logic                                                stray_rsp
);

    localparam int DW         = 8*DATA_WIDTH_BYTES;
    localparam int UM         = M_USER_BITS + ADDR_WIDTH;
    localparam int US         = S_USER_BITS + ADDR_WIDTH;
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMR_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TMR_LAST_I);
    localparam logic [TMR_W-1:0] TMR_MAX     = {TMR_W{1'b1}};
    localparam logic             TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_TERR = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             stray_q, stray_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] owner_next;
    logic [DW-1:0]    owner_data;
    logic [UM-1:0]    owner_user;
    logic             rsp_hs;

    // Rotating priority search: first requester at or after the pointer, wrapping.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    assign owner_data = req_data[owner_q*DW +: DW];
    assign owner_user = req_user[owner_q*UM +: UM];
    assign rsp_hs     = s_valid && rsp_ready[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            timer_q <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            stray_q <= stray_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        timer_d = timer_q;
        // Outside RESP the slave port is always ready, so any beat there is dropped.
        stray_d = s_valid && (state_q != ST_RESP);
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_ready) begin
                    ptr_d   = owner_next;
                    timer_d = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // A handshake in the expiry cycle takes precedence over the timeout.
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end else begin
                    if (timer_q != TMR_MAX) begin
                        timer_d = timer_q + 1'b1;
                    end
                    if (TIMEOUT_EN && (timer_q == TMR_LAST)) begin
                        state_d = ST_TERR;
                    end
                end
            end
            ST_TERR: begin
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_user  = '0;
        rsp_err   = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_user    = '0;
        s_ready   = 1'b1;
        busy      = 1'b0;
        case (state_q)
            ST_REQ: begin
                busy               = 1'b1;
                m_valid            = 1'b1;
                m_data             = owner_data;
                m_user             = owner_user;
                req_ready[owner_q] = m_ready;
            end
            ST_RESP: begin
                busy               = 1'b1;
                rsp_valid[owner_q] = s_valid;
                rsp_data           = s_data;
                rsp_user           = US'(s_user);
                s_ready            = rsp_ready[owner_q];
            end
            ST_TERR: begin
                busy               = 1'b1;
                rsp_valid[owner_q] = 1'b1;
                rsp_err            = 1'b1;
            end
            default: begin
                busy               = 1'b0;
            end
        endcase
    end

    assign stray_rsp = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_sra_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sra_arbiter                                               |
// | Description : Self-checking bench for sra_arbiter with a round-robin model.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sra_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int UM  = 10;
    localparam int US  = 10;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*DW-1:0] req_data;
    logic [N*UM-1:0] req_user;
    logic [DW-1:0]   rsp_data, m_data, s_data;
    logic [US-1:0]   rsp_user, s_user;
    logic [UM-1:0]   m_user;
    logic            rsp_err, m_valid, m_ready, s_valid, s_ready, busy, stray_rsp;

    int n_cmp = 0;
    int n_bad = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    sra_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH_BYTES(4), .ADDR_WIDTH(8),
        .M_USER_BITS(2), .S_USER_BITS(2), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_user(req_user),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_user(rsp_user),
        .rsp_err(rsp_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_user(s_user),
        .busy(busy), .stray_rsp(stray_rsp)
    );

    // Winner is the requester with the smallest forward distance from the pointer.
    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                d = (i - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic fill_payloads();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = $urandom;
            req_user[i*UM +: UM] = UM'($urandom);
        end
    endtask

    task automatic grant_one(input int r);
        @(negedge clk);
        fill_payloads();
        req_valid    = '0;
        req_valid[r] = 1'b1;
        m_ready      = 1'b1;
        s_valid      = 1'b0;
        rsp_ready    = '0;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        s_valid   = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, s_ready, m_valid, req_ready, rsp_valid, rsp_err, stray_rsp} !== {1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want %b",
                     {busy, s_ready, m_valid, req_ready, rsp_valid, rsp_err, stray_rsp}, 13'b0100000000000);
        end
        req_valid = '0;
        s_valid   = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        model_ptr = 0;
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, m_valid, stray_rsp} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_idle: got %b want 000", {busy, m_valid, stray_rsp});
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] mask;
        logic [N-1:0] oh;
        int           exp;
        logic [DW-1:0] sd;
        logic [US-1:0] su;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            mask = (t < 8) ? 4'hF : 4'($urandom_range(1, 15));
            fill_payloads();
            req_valid = mask;
            m_ready   = 1'b1;
            s_valid   = 1'b0;
            rsp_ready = '0;
            exp = rr_pick(mask, model_ptr);
            oh = '0;
            oh[exp] = 1'b1;
            @(negedge clk); #1;
            n_cmp++;
            if ({m_valid, req_ready, m_data, m_user} !== {1'b1, oh, req_data[exp*DW +: DW], req_user[exp*UM +: UM]}) begin
                n_bad++;
                $display("FAIL rr_grant t=%0d: got rdy=%b data=%h user=%h want rdy=%b data=%h user=%h",
                         t, req_ready, m_data, m_user, oh, req_data[exp*DW +: DW], req_user[exp*UM +: UM]);
            end
            model_ptr = (exp + 1) % N;
            @(negedge clk);
            req_valid = '0;
            sd = $urandom;
            su = US'($urandom);
            s_valid   = 1'b1;
            s_data    = sd;
            s_user    = su;
            rsp_ready = 4'hF;
            #1;
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_user, rsp_err, req_ready} !== {oh, sd, su, 1'b0, 4'h0}) begin
                n_bad++;
                $display("FAIL rr_rsp t=%0d: got v=%b d=%h u=%h e=%b want v=%b d=%h u=%h e=0",
                         t, rsp_valid, rsp_data, rsp_user, rsp_err, oh, sd, su);
            end
        end
        @(negedge clk);
        s_valid   = 1'b0;
        rsp_ready = '0;
    endtask

    task automatic test_single();
        logic [1:0]    mu;
        logic [DW-1:0] sd;
        @(negedge clk);
        fill_payloads();
        mu = 2'($urandom);
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        req_user[2*UM +: UM] = {8'h10, mu};
        req_valid = 4'b0100;
        m_ready   = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if ({m_valid, req_ready, m_data, m_user} !== {1'b1, 4'b0100, 32'hDEADBEEF, 8'h10, mu}) begin
            n_bad++;
            $display("FAIL single_req: got rdy=%b data=%h user=%h want rdy=0100 data=deadbeef user=%h",
                     req_ready, m_data, m_user, {8'h10, mu});
        end
        model_ptr = 3;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if ({busy, m_valid, rsp_valid} !== 6'b100000) begin
            n_bad++;
            $display("FAIL single_wait: got %b want 100000", {busy, m_valid, rsp_valid});
        end
        repeat (2) @(negedge clk);
        sd = $urandom;
        s_valid   = 1'b1;
        s_data    = sd;
        s_user    = {8'h10, 2'b01};
        rsp_ready = 4'b0100;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_user, rsp_err, s_ready} !== {4'b0100, sd, 8'h10, 2'b01, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL single_rsp: got v=%b d=%h u=%h e=%b sr=%b want v=0100 d=%h u=041 e=0 sr=1",
                     rsp_valid, rsp_data, rsp_user, rsp_err, s_ready, sd);
        end
        @(negedge clk);
        s_valid   = 1'b0;
        rsp_ready = '0;
        #1;
        n_cmp++;
        if ({busy, rsp_valid, stray_rsp} !== 6'b000000) begin
            n_bad++;
            $display("FAIL single_done: got %b want 000000", {busy, rsp_valid, stray_rsp});
        end
    endtask

    task automatic test_stall();
        int            r;
        logic [N-1:0]  oh;
        logic [DW-1:0] ed;
        logic [UM-1:0] eu;
        logic [DW-1:0] sd;
        r = $urandom_range(0, N-1);
        oh = '0;
        oh[r] = 1'b1;
        grant_one(r);
        m_ready = 1'b0;
        ed = req_data[r*DW +: DW];
        eu = req_user[r*UM +: UM];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({m_valid, req_ready, m_data, m_user, busy} !== {1'b1, 4'h0, ed, eu, 1'b1}) begin
                n_bad++;
                $display("FAIL stall_req c=%0d: got v=%b rdy=%b d=%h u=%h want v=1 rdy=0000 d=%h u=%h",
                         c, m_valid, req_ready, m_data, m_user, ed, eu);
            end
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        n_cmp++;
        if ({m_valid, req_ready, m_data} !== {1'b1, oh, ed}) begin
            n_bad++;
            $display("FAIL stall_hs: got v=%b rdy=%b d=%h want v=1 rdy=%b d=%h", m_valid, req_ready, m_data, oh, ed);
        end
        model_ptr = (r + 1) % N;
        @(negedge clk);
        req_valid = '0;
        sd = $urandom;
        s_valid   = 1'b1;
        s_data    = sd;
        s_user    = US'($urandom);
        rsp_ready = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if ({m_valid, rsp_valid, s_ready, busy, rsp_data} !== {1'b0, oh, 1'b0, 1'b1, sd}) begin
                n_bad++;
                $display("FAIL stall_rsp c=%0d: got mv=%b v=%b sr=%b busy=%b d=%h want mv=0 v=%b sr=0 busy=1 d=%h",
                         c, m_valid, rsp_valid, s_ready, busy, rsp_data, oh, sd);
            end
            @(negedge clk);
        end
        rsp_ready = oh;
        #1;
        n_cmp++;
        if ({rsp_valid, s_ready, busy} !== {oh, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_rsp_hs: got v=%b sr=%b busy=%b want v=%b sr=1 busy=1", rsp_valid, s_ready, busy, oh);
        end
        @(negedge clk);
        s_valid   = 1'b0;
        rsp_ready = '0;
        #1;
        n_cmp++;
        if ({busy, rsp_valid, stray_rsp, m_valid} !== 7'b0000000) begin
            n_bad++;
            $display("FAIL stall_done: got %b want 0000000", {busy, rsp_valid, stray_rsp, m_valid});
        end
    endtask

    task automatic test_timeout();
        int           r;
        logic [N-1:0] oh;
        r = $urandom_range(0, N-1);
        oh = '0;
        oh[r] = 1'b1;
        grant_one(r);
        @(negedge clk); #1;
        n_cmp++;
        if ({m_valid, req_ready} !== {1'b1, oh}) begin
            n_bad++;
            $display("FAIL tmo_grant: got v=%b rdy=%b want v=1 rdy=%b", m_valid, req_ready, oh);
        end
        model_ptr = (r + 1) % N;
        @(negedge clk);
        req_valid = '0;
        for (int c = 1; c <= TMO; c++) begin
            #1;
            n_cmp++;
            if ({rsp_valid, rsp_err, busy} !== {4'h0, 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL tmo_wait c=%0d: got v=%b e=%b busy=%b want v=0000 e=0 busy=1", c, rsp_valid, rsp_err, busy);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data, rsp_user, s_ready, busy} !== {oh, 1'b1, 32'h0, 10'h0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL tmo_err: got v=%b e=%b d=%h u=%h sr=%b want v=%b e=1 d=0 u=0 sr=1",
                     rsp_valid, rsp_err, rsp_data, rsp_user, s_ready, oh);
        end
        @(negedge clk);
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        n_cmp++;
        if ({busy, rsp_valid, rsp_err} !== 6'b000000) begin
            n_bad++;
            $display("FAIL tmo_done: got %b want 000000", {busy, rsp_valid, rsp_err});
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = $urandom;
        s_user  = US'($urandom);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        n_cmp++;
        if ({stray_rsp, rsp_valid, busy} !== {1'b1, 4'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL tmo_stray: got s=%b v=%b busy=%b want s=1 v=0000 busy=0", stray_rsp, rsp_valid, busy);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (stray_rsp !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_stray_pulse: got %b want 0", stray_rsp);
        end
    endtask

    task automatic test_expiry_handshake();
        int            r;
        logic [N-1:0]  oh;
        logic [DW-1:0] sd;
        logic [US-1:0] su;
        r = $urandom_range(0, N-1);
        oh = '0;
        oh[r] = 1'b1;
        grant_one(r);
        @(negedge clk);
        model_ptr = (r + 1) % N;
        @(negedge clk);
        req_valid = '0;
        repeat (TMO-1) @(negedge clk);
        sd = $urandom;
        su = US'($urandom);
        s_valid   = 1'b1;
        s_data    = sd;
        s_user    = su;
        rsp_ready = oh;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data, rsp_user} !== {oh, 1'b0, sd, su}) begin
            n_bad++;
            $display("FAIL expiry_rsp: got v=%b e=%b d=%h u=%h want v=%b e=0 d=%h u=%h",
                     rsp_valid, rsp_err, rsp_data, rsp_user, oh, sd, su);
        end
        @(negedge clk);
        s_valid   = 1'b0;
        rsp_ready = '0;
        #1;
        n_cmp++;
        if ({busy, rsp_valid, rsp_err, stray_rsp} !== 7'b0000000) begin
            n_bad++;
            $display("FAIL expiry_done: got %b want 0000000", {busy, rsp_valid, rsp_err, stray_rsp});
        end
    endtask

    task automatic test_reset_mid();
        grant_one(2);
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, s_ready, rsp_valid, m_valid, req_ready} !== {1'b0, 1'b1, 4'h0, 1'b0, 4'h0}) begin
            n_bad++;
            $display("FAIL rstmid_async: got %b want 01000000000", {busy, s_ready, rsp_valid, m_valid, req_ready});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        model_ptr = 0;
        fill_payloads();
        req_valid = 4'b1010;
        m_ready   = 1'b1;
        s_valid   = 1'b1;
        s_data    = $urandom;
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        n_cmp++;
        if ({m_valid, req_ready, m_data, stray_rsp} !== {1'b1, 4'b0010, req_data[1*DW +: DW], 1'b1}) begin
            n_bad++;
            $display("FAIL rstmid_grant: got v=%b rdy=%b d=%h stray=%b want v=1 rdy=0010 d=%h stray=1",
                     m_valid, req_ready, m_data, stray_rsp, req_data[1*DW +: DW]);
        end
        model_ptr = 2;
        @(negedge clk);
        req_valid = '0;
        s_valid   = 1'b1;
        rsp_ready = 4'b0010;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_err} !== {4'b0010, 1'b0}) begin
            n_bad++;
            $display("FAIL rstmid_rsp: got v=%b e=%b want v=0010 e=0", rsp_valid, rsp_err);
        end
        @(negedge clk);
        s_valid   = 1'b0;
        rsp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_user  = '0;
        rsp_ready = '0;
        m_ready   = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_user    = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_timeout();
        test_expiry_handshake();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sra_arbiter.md
Name: sra_arbiter

Overview:
- Shares one sra slave port among NUM_REQ sra masters using round-robin arbitration.
- Allows one outstanding transaction at a time: grant, forward one request beat, wait for exactly one response beat, route the response to the owner, then re-arbitrate.
- A response timeout returns an error beat, so a dead slave cannot hang a requester.
- Sits between register-access masters (CPU bridge, debug, DMA config) and a shared register bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH_BYTES, 4, data bytes per beat; DW = 8*DATA_WIDTH_BYTES.
- ADDR_WIDTH, 8, address bits.
- M_USER_BITS, 2, request user bits; UM = M_USER_BITS+ADDR_WIDTH, packed {addr, m_user}, m_user in LSBs.
- S_USER_BITS, 2, response user bits; US = S_USER_BITS+ADDR_WIDTH, packed the same way.
- TIMEOUT_CYCLES, 255, cycles to wait for a response; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request ready.
- req_data  in  NUM_REQ*DW  request data, requester i at slice i.
- req_user  in  NUM_REQ*UM  request user (addr + m_user).
- rsp_valid  out  NUM_REQ  per-requester response valid.
- rsp_ready  in  NUM_REQ  per-requester response ready.
- rsp_data  out  DW  response data, shared by all requesters, qualified by rsp_valid.
- rsp_user  out  US  response user, shared.
- rsp_err  out  1  1 = timeout-generated response, qualified by rsp_valid.
- m_valid / m_ready / m_data / m_user  out/in/out/out  1/1/DW/UM  request stream to the slave (sra M->S).
- s_valid / s_ready / s_data / s_user  in/out/in/in  1/1/DW/US  response stream from the slave (sra S->M).
- busy  out  1  high in any state other than IDLE.
- stray_rsp  out  1  one-cycle pulse when an unexpected response is discarded.

Behaviour:
- Handshake: a transfer occurs when valid && ready on a rising clk edge. Once valid is asserted by this block, it holds valid and payload stable until ready.
- Reset values:
  - All outputs 0, except s_ready = 1.
  - State IDLE, priority pointer = 0, owner = 0, timer = 0.
- IDLE:
  - If any req_valid is set, pick the first set bit at or after the pointer (wrapping), register it as owner, and go to REQ. IDLE->REQ takes 1 cycle.
  - Otherwise stay in IDLE.
  - s_ready = 1 in IDLE; any s_valid beat here is discarded and pulses stray_rsp.
- REQ:
  - m_valid = 1. m_data/m_user are muxed combinationally from the owner's slice.
  - req_ready[owner] = m_ready; all other req_ready bits = 0.
  - On the m handshake: pointer = (owner+1) mod NUM_REQ, timer = 0, go to RESP.
  - Once granted, a requester must not drop req_valid before its handshake; dropping it is undefined.
  - s_ready = 1 in REQ; a beat arriving here is stray, is discarded, and pulses stray_rsp.
- RESP:
  - rsp_valid[owner] = s_valid; rsp_data/rsp_user pass through from s_data/s_user; rsp_err = 0; s_ready = rsp_ready[owner].
  - On the s handshake, go to IDLE.
  - The timer increments every RESP cycle that has no handshake.
  - If TIMEOUT_CYCLES != 0 and the timer reaches TIMEOUT_CYCLES, go to TERR.
  - A handshake in the same cycle the timer expires wins: the response is delivered and no error is raised.
- TERR:
  - rsp_valid[owner] = 1, rsp_err = 1, rsp_data = 0, rsp_user = 0.
  - s_ready = 1, so late beats are discarded and pulse stray_rsp.
  - On rsp_ready[owner], go to IDLE.
- Timer width: clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Minimum transaction: IDLE, REQ and RESP each take at least 1 cycle, so at most one transaction completes every 3 cycles.
- Fairness: a continuously requesting master waits at most NUM_REQ-1 transactions.
- Reset mid-transaction: everything returns to reset values immediately. An in-flight slave response arriving after reset is treated as stray.

Test Plan:
- Single requester 2 writes addr 0x10, data 0xDEADBEEF; slave responds user {0x10,2'b01} after 3 cycles -> m beat matches requester 2's payload exactly; rsp_valid = 4'b0100 with data/user passed through; rsp_err = 0.
- All 4 requesters hold req_valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3; non-owners see req_ready = 0 throughout.
- Slave m_ready = 0 for 5 cycles, then response with rsp_ready[owner] stalled 4 cycles -> payloads stay stable; no beat is lost or duplicated; busy stays high until the response handshake.
- TIMEOUT_CYCLES = 8, slave silent -> after 8 RESP cycles the owner receives rsp_err = 1, data 0; a late s_valid 3 cycles later pulses stray_rsp for 1 cycle and reaches no requester.
- Response handshake on the exact expiry cycle -> normal response delivered, rsp_err = 0, no TERR entry.
- rst_n asserted while in RESP -> outputs reset asynchronously, pointer = 0; after release, requesters 1 and 3 requesting -> grant goes to 1 first.
